// File: rtl/adder_pipelined_nbit.sv
// Pipelined WIDTH-bit adder: carry chain cut into STAGES registered slices with valid/ready flow control.
// Optional signed-overflow output enabled by defining OVERFLOW_FLAG_EN.
module adder_pipelined_nbit #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             overflow
`endif
);

  localparam int SW = WIDTH / STAGES;

  // Stage k register holds sum slices 0..k, the carry into slice k+1 and the operands.
  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] c_q, c_d;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
`ifdef OVERFLOW_FLAG_EN
  logic              ovf_q, ovf_d;
`endif

  logic adv;

  // The whole pipeline moves as one: a stalled output freezes every stage.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_comb begin : stage_next
    logic [WIDTH-1:0] a_k, b_k, s_k;
    logic             c_k, v_k;
    logic [SW:0]      slice_k;
    a_k     = '0;
    b_k     = '0;
    s_k     = '0;
    c_k     = 1'b0;
    v_k     = 1'b0;
    slice_k = '0;
`ifdef OVERFLOW_FLAG_EN
    ovf_d   = 1'b0;
`endif
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        a_k = a;
        b_k = b;
        s_k = '0;
        c_k = cin;
        // NOTE: valid comes only from in_valid, so unknown operands during a bubble never reach a valid bit.
        v_k = in_valid;
      end else begin
        a_k = a_q[k-1];
        b_k = b_q[k-1];
        s_k = s_q[k-1];
        c_k = c_q[k-1];
        v_k = v_q[k-1];
      end
      slice_k = {1'b0, a_k[k*SW +: SW]} + {1'b0, b_k[k*SW +: SW]} + {{SW{1'b0}}, c_k};
      s_k[k*SW +: SW] = slice_k[SW-1:0];
      a_d[k] = a_k;
      b_d[k] = b_k;
      s_d[k] = s_k;
      c_d[k] = slice_k[SW];
      v_d[k] = v_k;
`ifdef OVERFLOW_FLAG_EN
      if (k == STAGES - 1) begin
        ovf_d = (a_k[WIDTH-1] == b_k[WIDTH-1]) && (s_k[WIDTH-1] != a_k[WIDTH-1]);
      end
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples its predecessor's old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      c_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
`ifdef OVERFLOW_FLAG_EN
      ovf_q <= 1'b0;
`endif
    end else if (adv) begin
      v_q <= v_d;
      c_q <= c_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
`ifdef OVERFLOW_FLAG_EN
      ovf_q <= ovf_d;
`endif
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
`ifdef OVERFLOW_FLAG_EN
  assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_adder_pipelined_nbit.sv
// Bench for adder_pipelined_nbit: 32/4 directed + random flow-control runs, plus
// exhaustive 4-bit runs with STAGES=1 and STAGES=2, all checked against an arithmetic scoreboard.
module tb_adder_pipelined_nbit;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, sum;
  logic        cin, cout, ovf_w;

  int n_tests = 0;
  int n_fail  = 0;
  bit small_go = 0;
  bit small_done [2];

  logic [33:0] mq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  adder_pipelined_nbit #(.WIDTH(32), .STAGES(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef OVERFLOW_FLAG_EN
    , .overflow(ovf_w)
`endif
  );
`ifndef OVERFLOW_FLAG_EN
  assign ovf_w = 1'b0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: {overflow, cout, sum} from plain integer addition.
  function automatic logic [33:0] model32(input logic [31:0] x, input logic [31:0] y, input logic c);
    logic [32:0] t;
    t = {1'b0, x} + {1'b0, y} + {32'd0, c};
`ifdef OVERFLOW_FLAG_EN
    return {(x[31] == y[31]) && (t[31] != x[31]), t};
`else
    return {1'b0, t};
`endif
  endfunction

  // Scoreboard: accepts push expected results, every valid output is compared to the oldest one.
  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
    end else begin
      if (out_valid) begin
        check("unexpected_out_valid", mq.size() == 0, 0);
        if (mq.size() > 0) begin
          check("result32", {30'd0, ovf_w, cout, sum}, {30'd0, mq[0]});
          if (out_ready) void'(mq.pop_front());
        end
      end
      if (in_valid && in_ready) mq.push_back(model32(a, b, cin));
    end
  end

  task automatic idle();
    in_valid = 1'b0;
    a = 'x;
    b = 'x;
    cin = 1'bx;
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic c);
    bit acc;
    int n;
    in_valid = 1'b1;
    a = x;
    b = y;
    cin = c;
    n = 0;
    acc = 1'b0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    check("send_accepted", acc, 1);
  endtask

  task automatic run_one(input logic [31:0] x, input logic [31:0] y, input logic c,
                         output logic [33:0] r, output int lat);
    send(x, y, c);
    idle();
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("run_one_valid", out_valid, 1);
    r = {ovf_w, cout, sum};
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (mq.size() > 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, mq.size(), 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Exhaustive 4-bit runs: STAGES=1 (j=0) and STAGES=2 (j=1), random bubbles and backpressure.
  for (genvar j = 0; j < 2; j++) begin : g_small
    logic [3:0] sa, sb, ssum;
    logic       scin, siv, sir, sov, sor, scout, sovf;
    logic [5:0] q[$];
    int         n_out = 0;

    adder_pipelined_nbit #(.WIDTH(4), .STAGES(j + 1)) u_small (
      .clk(clk), .rst(rst), .in_valid(siv), .in_ready(sir),
      .a(sa), .b(sb), .cin(scin), .out_valid(sov), .out_ready(sor),
      .sum(ssum), .cout(scout)
`ifdef OVERFLOW_FLAG_EN
      , .overflow(sovf)
`endif
    );
`ifndef OVERFLOW_FLAG_EN
    assign sovf = 1'b0;
`endif

    function automatic logic [5:0] model4(input logic [3:0] x, input logic [3:0] y, input logic c);
      logic [4:0] t;
      t = {1'b0, x} + {1'b0, y} + {4'd0, c};
`ifdef OVERFLOW_FLAG_EN
      return {(x[3] == y[3]) && (t[3] != x[3]), t};
`else
      return {1'b0, t};
`endif
    endfunction

    always @(negedge clk) begin
      if (rst) begin
        q.delete();
      end else begin
        if (sov) begin
          check($sformatf("small%0d_unexpected_out_valid", j), q.size() == 0, 0);
          if (q.size() > 0) begin
            check($sformatf("small%0d_result", j), {58'd0, sovf, scout, ssum}, {58'd0, q[0]});
            if (sor) begin
              void'(q.pop_front());
              n_out++;
            end
          end
        end
        if (siv && sir) q.push_back(model4(sa, sb, scin));
      end
    end

    initial begin
      int  i, cyc;
      bit  acc;
      logic [8:0] combo;
      siv = 1'b0; sa = '0; sb = '0; scin = 1'b0; sor = 1'b1;
      wait (small_go);
      @(posedge clk);
      #1;
      i = 0;
      cyc = 0;
      while (i < 512 && cyc < 5000) begin
        if ($urandom_range(0, 4) == 0) begin
          siv = 1'b0; sa = 'x; sb = 'x; scin = 1'bx;
        end else begin
          combo = 9'(i);
          siv = 1'b1;
          {sa, sb, scin} = combo;
        end
        sor = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        acc = siv && sir;
        @(posedge clk);
        #1;
        if (acc) i++;
        cyc++;
      end
      siv = 1'b0;
      sor = 1'b1;
      cyc = 0;
      while (q.size() > 0 && cyc < 50) begin
        @(posedge clk);
        #1;
        cyc++;
      end
      check($sformatf("small%0d_accepted", j), i, 512);
      check($sformatf("small%0d_drained", j), q.size(), 0);
      check($sformatf("small%0d_outputs", j), n_out, 512);
      small_done[j] = 1'b1;
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [33:0] r;
    int lat, n;
    bit rand_done;

    rst = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    #12 rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_sum", sum, 0);
    check("reset_cout", cout, 0);
    check("reset_overflow", ovf_w, 0);
    check("reset_in_ready", in_ready, 1);

    // Carry must ripple across every slice boundary.
    run_one(32'hFFFF_FFFF, 32'h1, 1'b0, r, lat);
    check("t1_sum", r[31:0], 32'h0);
    check("t1_cout", r[32], 1);
    check("t1_edges_after_accept", lat, 3);

    run_one(32'h1234_5678, 32'h0FED_CBA9, 1'b1, r, lat);
    check("pin_sum", r[31:0], 32'h2222_2222);
    check("pin_cout", r[32], 0);

    // Eight back-to-back ops; outputs must appear on 8 consecutive cycles.
    in_valid = 1'b1; a = 32'd0; b = 32'd0; cin = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("b2b_valid_%0d", k), out_valid, (k >= 3 && k <= 10));
      if (k == 3) check("b2b_first_sum", sum, 32'h0);
      if (k == 10) check("b2b_last_sum", sum, 32'h7000_0008);
      if (k + 1 < 8) begin
        a = 32'(k + 1);
        b = 32'(k + 1) << 28;
        cin = ((k + 1) % 2) == 1;
      end else begin
        idle();
      end
    end
    drain("b2b_drain");

    // Backpressure: 5 stalled cycles in the middle of a running stream.
    fork
      begin
        for (int i = 0; i < 12; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)));
        idle();
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(posedge clk);
          #1;
          check("stall_out_valid", out_valid, 1);
          check("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
      end
    join
    drain("stall_drain");

    // Random traffic with random backpressure.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            idle();
            @(posedge clk);
            #1;
          end else begin
            send(pick(), pick(), 1'($urandom_range(0, 1)));
          end
        end
        idle();
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          out_ready = ($urandom_range(0, 2) != 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain("random_drain");

    // Reset with three ops in flight: immediate clear, nothing emerges afterwards.
    out_ready = 1'b1;
    send(32'h1, 32'h2, 1'b0);
    send(32'h3, 32'h4, 1'b1);
    send(32'h5, 32'h6, 1'b0);
    idle();
    #2 rst = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_sum", sum, 0);
    check("async_rst_cout", cout, 0);
    #3 rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      check("no_ghost_after_rst", out_valid, 0);
    end

    run_one(32'h7FFF_FFFF, 32'h1, 1'b0, r, lat);
    check("ovf1_sum", r[31:0], 32'h8000_0000);
    check("ovf1_cout", r[32], 0);
`ifdef OVERFLOW_FLAG_EN
    check("ovf1_flag", r[33], 1);
`endif
    run_one(32'h8000_0000, 32'h8000_0000, 1'b0, r, lat);
    check("ovf2_sum", r[31:0], 32'h0);
    check("ovf2_cout", r[32], 1);
`ifdef OVERFLOW_FLAG_EN
    check("ovf2_flag", r[33], 1);
`endif
    drain("final_drain");

    small_go = 1'b1;
    n = 0;
    while (!(small_done[0] && small_done[1]) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    check("small_runs_done", small_done[0] && small_done[1], 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
